// File: rtl/mc_router_stage_if.sv
// Link bundle for mc_router_stage: upstream req/bussy input and downstream req/bussy output.
// The stage itself connects through the slave modport; neighbours or a bench drive the master side.
interface mc_router_stage_if #(
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] input_data;
  logic              input_req;
  logic              input_bussy;
  logic [FLIT_W-1:0] output_data;
  logic              output_req;
  logic              output_bussy;

  modport master (
    output input_data, input_req, output_bussy,
    input  input_bussy, output_data, output_req
  );

  modport slave (
    input  input_data, input_req, output_bussy,
    output input_bussy, output_data, output_req
  );
endinterface

// File: rtl/mc_router_stage.sv
// Router stage: per-class FWFT FIFOs, packet-atomic highest-class-first forwarding.
// Optional starvation guard enabled by defining STARVE_GUARD_EN.
module mc_router_stage #(
  parameter int FLIT_W       = 16,
  parameter int DEPTH        = 4,
  parameter int NUM_CLASS    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mc_router_stage_if.slave     link,
  output logic [NUM_CLASS-1:0] class_empty,
  output logic                 drop_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CLS_W = (NUM_CLASS > 1) ? $clog2(NUM_CLASS) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [2:0] K_BODY   = 3'b100;
  localparam logic [2:0] K_SINGLE = 3'b101;
  localparam logic [2:0] K_RSVD   = 3'b110;
  localparam logic [2:0] K_TAIL   = 3'b111;

  function automatic logic [CLS_W-1:0] clamp_cls(input logic [1:0] raw);
    if (int'(raw) >= NUM_CLASS) return CLS_W'(NUM_CLASS - 1);
    return raw[CLS_W-1:0];
  endfunction

  logic [FLIT_W-1:0]    mem       [NUM_CLASS][DEPTH];
  logic [PTR_W-1:0]     wr_ptr    [NUM_CLASS];
  logic [PTR_W-1:0]     rd_ptr    [NUM_CLASS];
  logic [PTR_W:0]       count     [NUM_CLASS];
  logic [FLIT_W-1:0]    head_flit [NUM_CLASS];
  logic [NUM_CLASS-1:0] full, empty, is_start, push, pop;

  logic [2:0]       in_kind;
  logic             in_head, in_mid, malformed, in_xfer, in_open;
  logic [CLS_W-1:0] tgt, in_cls;

  logic [0:0]       state;
  logic [CLS_W-1:0] lock_cls, held_cls, sel, pick_hi;
  logic             held, out_xfer;
  logic [2:0]       out_kind;

`ifdef STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;
  logic [CLS_W-1:0] pick_lo;
  logic             lower_waiting;
`endif

  // A class is grantable only when its oldest entry starts a packet; orphans are skipped.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      empty[c]     = (count[c] == '0);
      full[c]      = (count[c] == (PTR_W+1)'(DEPTH));
      head_flit[c] = mem[c][rd_ptr[c]];
      is_start[c]  = !empty[c] &&
                     (!head_flit[c][FLIT_W-1] || head_flit[c][FLIT_W-1 -: 3] == K_SINGLE);
    end
  end

  assign class_empty = empty;

  always_comb begin
    in_kind   = link.input_data[FLIT_W-1 -: 3];
    in_head   = !in_kind[2];
    in_mid    = (in_kind == K_BODY) || (in_kind == K_TAIL);
    tgt       = in_cls;
    if (in_head)
      tgt = clamp_cls(in_kind[1:0]);
    else if (in_kind == K_SINGLE)
      tgt = clamp_cls(link.input_data[1:0]);
    malformed        = (in_head && in_open) || (in_mid && !in_open) || (in_kind == K_RSVD);
    link.input_bussy = !malformed && full[tgt];
    in_xfer          = link.input_req && !link.input_bussy;
    push             = '0;
    if (in_xfer && !malformed)
      push[tgt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_open  <= 1'b0;
      in_cls   <= '0;
      drop_err <= 1'b0;
    end else begin
      drop_err <= in_xfer && malformed;
      if (in_xfer && !malformed) begin
        if (in_head) begin
          in_open <= 1'b1;
          in_cls  <= tgt;
        end else if (in_kind == K_TAIL) begin
          in_open <= 1'b0;
        end
      end
    end
  end

  // A held grant or a lock overrides fresh arbitration so the presented flit never changes under backpressure.
  always_comb begin
    pick_hi = '0;
    for (int c = 0; c < NUM_CLASS; c++)
      if (is_start[c]) pick_hi = CLS_W'(c);
    sel = pick_hi;
`ifdef STARVE_GUARD_EN
    pick_lo = '0;
    for (int c = NUM_CLASS - 1; c >= 0; c--)
      if (is_start[c]) pick_lo = CLS_W'(c);
    if (starve_cnt >= CNT_W'(STARVE_LIMIT))
      sel = pick_lo;
`endif
    if (state == LOCKED)
      sel = lock_cls;
    else if (held)
      sel = held_cls;
    link.output_req  = (state == LOCKED) ? !empty[lock_cls] : (held || (|is_start));
    link.output_data = link.output_req ? head_flit[sel] : '0;
    out_xfer         = link.output_req && !link.output_bussy;
    out_kind         = head_flit[sel][FLIT_W-1 -: 3];
    pop              = '0;
    if (out_xfer)
      pop[sel] = 1'b1;
`ifdef STARVE_GUARD_EN
    lower_waiting = 1'b0;
    for (int c = 0; c < NUM_CLASS; c++)
      if (c < int'(sel) && is_start[c]) lower_waiting = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      lock_cls <= '0;
      held     <= 1'b0;
      held_cls <= '0;
    end else if (state == IDLE) begin
      if (out_xfer) begin
        held <= 1'b0;
        if (!out_kind[2]) begin
          state    <= LOCKED;
          lock_cls <= sel;
        end
      end else if (link.output_req) begin
        held     <= 1'b1;
        held_cls <= sel;
      end
    end else if (out_xfer && out_kind == K_TAIL) begin
      state <= IDLE;
    end
  end

`ifdef STARVE_GUARD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      starve_cnt <= '0;
    else if (state == IDLE && out_xfer) begin
      if (!lower_waiting)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_W'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        count[c] <= count[c] + (PTR_W+1)'(push[c]) - (PTR_W+1)'(pop[c]);
      end
    end
  end

  // Storage needs no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CLASS; c++)
      if (push[c]) mem[c][wr_ptr[c]] <= link.input_data;
  end

endmodule

// File: tb/tb_mc_router_stage.sv
// Self-checking bench for mc_router_stage: directed scenarios plus randomized traffic vs a queue model.
// Compile with STARVE_GUARD_EN defined to also exercise the starvation guard.
module tb_mc_router_stage;

  localparam int FW    = 16;
  localparam int DEPTH = 4;
  localparam int NC    = 2;
  localparam int LIMIT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NC-1:0] class_empty;
  logic          drop_err;

  always #5 clk = ~clk;

  mc_router_stage_if #(.FLIT_W(FW)) link ();

  mc_router_stage #(
    .FLIT_W(FW), .DEPTH(DEPTH), .NUM_CLASS(NC), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .link(link), .class_empty(class_empty), .drop_err(drop_err)
  );

  // Reference model: one queue per class plus packet-level input/output state.
  logic [FW-1:0] mq [NC][$];
  bit m_open, m_locked, m_drop;
  int m_cls, m_lock, m_hold, m_starve;

  bit            exp_ibussy, exp_oreq, exp_drop, exp_mal;
  logic [FW-1:0] exp_odata;
  logic [NC-1:0] exp_empty;
  int            exp_tgt, exp_sel;

  logic          obs_ibussy, obs_oreq, obs_drop;
  logic [FW-1:0] obs_odata;
  logic [NC-1:0] obs_empty;
  logic [FW-1:0] stream [$];

  int checks = 0;
  int passes = 0;

  function automatic int clampc(int c);
    return (c >= NC) ? NC - 1 : c;
  endfunction

  function automatic bit starts(int c);
    if (mq[c].size() == 0) return 1'b0;
    return (mq[c][0][FW-1] == 1'b0) || (mq[c][0][FW-1:FW-3] == 3'b101);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    m_open = 0; m_locked = 0; m_drop = 0;
    m_cls = 0; m_lock = 0; m_hold = -1; m_starve = 0;
  endtask

  task automatic model_predict();
    logic [2:0] k;
    k = link.input_data[FW-1:FW-3];
    if (!k[2])             exp_tgt = clampc(int'(k[1:0]));
    else if (k == 3'b101)  exp_tgt = clampc(int'(link.input_data[1:0]));
    else                   exp_tgt = m_cls;
    exp_mal    = (!k[2] && m_open) || ((k == 3'b100 || k == 3'b111) && !m_open) || (k == 3'b110);
    exp_ibussy = !exp_mal && (mq[exp_tgt].size() == DEPTH);
    exp_sel    = -1;
    if (m_locked) begin
      exp_sel  = m_lock;
      exp_oreq = mq[m_lock].size() > 0;
    end else if (m_hold >= 0) begin
      exp_sel  = m_hold;
      exp_oreq = 1'b1;
    end else begin
      for (int c = NC - 1; c >= 0; c--)
        if (exp_sel < 0 && starts(c)) exp_sel = c;
`ifdef STARVE_GUARD_EN
      if (m_starve >= LIMIT) begin
        exp_sel = -1;
        for (int c = 0; c < NC; c++)
          if (exp_sel < 0 && starts(c)) exp_sel = c;
      end
`endif
      exp_oreq = exp_sel >= 0;
    end
    exp_odata = exp_oreq ? mq[exp_sel][0] : '0;
    exp_drop  = m_drop;
    for (int c = 0; c < NC; c++) exp_empty[c] = (mq[c].size() == 0);
  endtask

  task automatic model_commit(input logic r, input logic ob);
    logic [FW-1:0] f;
    bit lower, new_drop;
    new_drop = r && !exp_ibussy && exp_mal;
    if (exp_oreq && !ob) begin
      lower = 0;
      for (int c = 0; c < exp_sel; c++) if (starts(c)) lower = 1;
      f = mq[exp_sel].pop_front();
      if (!m_locked) begin
        m_starve = lower ? m_starve + 1 : 0;
        m_hold   = -1;
        if (!f[FW-1]) begin
          m_locked = 1;
          m_lock   = exp_sel;
        end
      end else if (f[FW-1:FW-3] == 3'b111) begin
        m_locked = 0;
      end
    end else if (exp_oreq && !m_locked) begin
      m_hold = exp_sel;
    end
    if (r && !exp_ibussy && !exp_mal) begin
      mq[exp_tgt].push_back(link.input_data);
      if (!link.input_data[FW-1]) begin
        m_open = 1;
        m_cls  = exp_tgt;
      end else if (link.input_data[FW-1:FW-3] == 3'b111) begin
        m_open = 0;
      end
    end
    m_drop = new_drop;
  endtask

  // One clock of stimulus: drive at negedge, sample 1ns later, advance the model at posedge.
  task automatic cycle(input logic [FW-1:0] d, input logic r, input logic ob);
    @(negedge clk);
    link.input_data   = d;
    link.input_req    = r;
    link.output_bussy = ob;
    #1;
    model_predict();
    obs_ibussy = link.input_bussy;
    obs_oreq   = link.output_req;
    obs_odata  = link.output_data;
    obs_drop   = drop_err;
    obs_empty  = class_empty;
    if (obs_oreq && !ob) stream.push_back(obs_odata);
    @(posedge clk);
    model_commit(r, ob);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst               = 1'b0;
    link.input_req    = 1'b0;
    link.input_data   = '0;
    link.output_bussy = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
    @(posedge clk);
    stream.delete();
  endtask

  task automatic gen_flit(output logic [FW-1:0] f);
    int         roll;
    logic [12:0] pay;
    logic [1:0] cc;
    roll = $urandom_range(0, 99);
    pay  = 13'($urandom);
    cc   = 2'($urandom);
    if (roll < 8) begin
      if (roll < 3)       f = {3'b110, pay};
      else if (m_open)    f = {1'b0, cc, pay};
      else                f = {3'b100, pay};
    end else if (roll < 30) f = {3'b101, pay[12:2], cc};
    else if (m_open)        f = (roll < 65) ? {3'b100, pay} : {3'b111, pay};
    else                    f = {1'b0, cc, pay};
  endtask

  task automatic test_reset();
    do_reset();
    cycle(16'h0001, 1'b1, 1'b1);
    cycle(16'h8002, 1'b1, 1'b1);
    cycle(16'h0000, 1'b0, 1'b1);
    checks++; if (obs_empty !== 2'b10) $display("[TB] FAIL reset_prefill_empty got %b want %b", obs_empty, 2'b10); else passes++;
    checks++; if (obs_oreq !== 1'b1) $display("[TB] FAIL reset_prefill_oreq got %b want 1", obs_oreq); else passes++;
    @(negedge clk);
    link.input_req  = 1'b1;
    link.input_data = 16'h0005;
    #2 rst = 1'b0;
    #1;
    checks++; if (link.output_req !== 1'b0) $display("[TB] FAIL reset_oreq got %b want 0", link.output_req); else passes++;
    checks++; if (link.output_data !== 16'h0000) $display("[TB] FAIL reset_odata got %h want 0000", link.output_data); else passes++;
    checks++; if (link.input_bussy !== 1'b0) $display("[TB] FAIL reset_ibussy got %b want 0", link.input_bussy); else passes++;
    checks++; if (drop_err !== 1'b0) $display("[TB] FAIL reset_drop got %b want 0", drop_err); else passes++;
    checks++; if (class_empty !== 2'b11) $display("[TB] FAIL reset_empty got %b want 11", class_empty); else passes++;
    link.input_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    cycle(16'h8003, 1'b1, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0);
    checks++; if (obs_drop !== 1'b1) $display("[TB] FAIL reset_open_cleared drop got %b want 1", obs_drop); else passes++;
    checks++; if (obs_empty !== 2'b11) $display("[TB] FAIL reset_orphan_body empty got %b want 11", obs_empty); else passes++;
  endtask

  task automatic test_priority();
    logic [FW-1:0] want [7];
    logic [FW-1:0] got;
    want = '{16'h2010, 16'hE011, 16'h2004, 16'hE005, 16'h0001, 16'h8002, 16'hE003};
    do_reset();
    cycle(16'h2010, 1'b1, 1'b0);
    cycle(16'hE011, 1'b1, 1'b0);
    cycle(16'h0001, 1'b1, 1'b1);
    cycle(16'h8002, 1'b1, 1'b1);
    cycle(16'hE003, 1'b1, 1'b1);
    cycle(16'h2004, 1'b1, 1'b1);
    cycle(16'hE005, 1'b1, 1'b1);
    repeat (12) cycle(16'h0000, 1'b0, 1'b0);
    checks++; if (stream.size() != 7) $display("[TB] FAIL prio_count got %0d want 7", stream.size()); else passes++;
    for (int i = 0; i < 7; i++) begin
      got = (i < stream.size()) ? stream[i] : 16'hxxxx;
      checks++; if (got !== want[i]) $display("[TB] FAIL prio_order[%0d] got %h want %h", i, got, want[i]); else passes++;
    end
  endtask

  task automatic test_atomicity();
    logic [FW-1:0] want [4];
    logic [FW-1:0] got;
    want = '{16'h0011, 16'h8012, 16'hE013, 16'hA001};
    do_reset();
    cycle(16'h0011, 1'b1, 1'b0);
    cycle(16'hA001, 1'b1, 1'b0);
    cycle(16'h0000, 1'b0, 1'b0);
    checks++; if (obs_oreq !== 1'b0) $display("[TB] FAIL atom_locked_idle oreq got %b want 0", obs_oreq); else passes++;
    cycle(16'h8012, 1'b1, 1'b0);
    cycle(16'hE013, 1'b1, 1'b0);
    repeat (6) cycle(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = (i < stream.size()) ? stream[i] : 16'hxxxx;
      checks++; if (got !== want[i]) $display("[TB] FAIL atom_order[%0d] got %h want %h", i, got, want[i]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] flits [5];
    logic [FW-1:0] got;
    bit accepted;
    flits = '{16'h0021, 16'h8022, 16'h8023, 16'h8024, 16'hE025};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(flits[i], 1'b1, 1'b1);
      checks++;
      if (obs_ibussy !== (i == 4)) $display("[TB] FAIL bp_ibussy[%0d] got %b want %b", i, obs_ibussy, (i == 4));
      else passes++;
    end
    accepted = 0;
    for (int t = 0; t < 10 && !accepted; t++) begin
      cycle(flits[4], 1'b1, 1'b0);
      if (obs_ibussy === 1'b0) accepted = 1;
    end
    checks++; if (accepted !== 1'b1) $display("[TB] FAIL bp_fifth_accept got %b want 1", accepted); else passes++;
    repeat (8) cycle(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      got = (i < stream.size()) ? stream[i] : 16'hxxxx;
      checks++; if (got !== flits[i]) $display("[TB] FAIL bp_order[%0d] got %h want %h", i, got, flits[i]); else passes++;
    end
  endtask

  task automatic test_malformed();
    do_reset();
    cycle(16'h8abc, 1'b1, 1'b0);
    checks++; if (obs_ibussy !== 1'b0) $display("[TB] FAIL mal_ibussy got %b want 0", obs_ibussy); else passes++;
    checks++; if (obs_drop !== 1'b0) $display("[TB] FAIL mal_drop_early got %b want 0", obs_drop); else passes++;
    cycle(16'h0000, 1'b0, 1'b0);
    checks++; if (obs_drop !== 1'b1) $display("[TB] FAIL mal_drop_pulse got %b want 1", obs_drop); else passes++;
    cycle(16'h0000, 1'b0, 1'b0);
    checks++; if (obs_drop !== 1'b0) $display("[TB] FAIL mal_drop_end got %b want 0", obs_drop); else passes++;
    checks++; if (obs_empty !== 2'b11) $display("[TB] FAIL mal_not_stored empty got %b want 11", obs_empty); else passes++;
    checks++; if (stream.size() != 0) $display("[TB] FAIL mal_no_output got %0d want 0", stream.size()); else passes++;
  endtask

  task automatic test_random();
    logic [FW-1:0] f;
    logic r, ob;
    do_reset();
    gen_flit(f);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 3) != 0);
      ob = ($urandom_range(0, 2) == 0);
      cycle(f, r, ob);
      checks++; if (obs_ibussy !== exp_ibussy) $display("[TB] FAIL rand_ibussy cyc %0d got %b want %b", i, obs_ibussy, exp_ibussy); else passes++;
      checks++; if (obs_oreq !== exp_oreq) $display("[TB] FAIL rand_oreq cyc %0d got %b want %b", i, obs_oreq, exp_oreq); else passes++;
      checks++; if (obs_odata !== exp_odata) $display("[TB] FAIL rand_odata cyc %0d got %h want %h", i, obs_odata, exp_odata); else passes++;
      checks++; if (obs_drop !== exp_drop) $display("[TB] FAIL rand_drop cyc %0d got %b want %b", i, obs_drop, exp_drop); else passes++;
      checks++; if (obs_empty !== exp_empty) $display("[TB] FAIL rand_empty cyc %0d got %b want %b", i, obs_empty, exp_empty); else passes++;
      if (r && !exp_ibussy) gen_flit(f);
    end
  endtask

`ifdef STARVE_GUARD_EN
  task automatic test_starvation();
    logic [FW-1:0] want [4];
    logic [FW-1:0] got;
    want = '{16'hA101, 16'hA105, 16'hA000, 16'hA109};
    do_reset();
    cycle(16'hA101, 1'b1, 1'b1);
    cycle(16'hA000, 1'b1, 1'b1);
    cycle(16'hA105, 1'b1, 1'b1);
    cycle(16'hA109, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(16'hA10D + 16'(4 * i), 1'b1, 1'b0);
    repeat (10) cycle(16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      got = (i < stream.size()) ? stream[i] : 16'hxxxx;
      checks++; if (got !== want[i]) $display("[TB] FAIL starve_order[%0d] got %h want %h", i, got, want[i]); else passes++;
    end
  endtask
`endif

  initial begin
    link.input_data   = '0;
    link.input_req    = 1'b0;
    link.output_bussy = 1'b0;
    model_reset();
    test_reset();
    test_priority();
    test_atomicity();
    test_backpressure();
    test_malformed();
    test_random();
`ifdef STARVE_GUARD_EN
    test_starvation();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
